// File: rtl/mem_arb_pkg.sv
// Shared types and reset values for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } arb_state_e;

  typedef enum logic [1:0] {
    GntNone,
    GntI,
    GntD
  } gnt_src_e;

  localparam arb_state_e RstState = StIdle;
  localparam logic       RstReq   = 1'b0;
  localparam logic       RstRdy   = 1'b0;
  localparam logic       RstValid = 1'b0;

endpackage

// File: rtl/ifetch_buf.sv
// One-entry fetch buffer: tag compare on lookup, fill on completed fetch,
// invalidate on a completed write to the tagged address.
module ifetch_buf
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] lookup_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] rdata_o,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [DW-1:0] fill_data_i,
  input  logic          inv_i,
  input  logic [AW-1:0] inv_addr_i
);

  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;

  assign hit_o   = valid_q && (tag_q == lookup_addr_i);
  assign rdata_o = data_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_addr_i;
      data_d  = fill_data_i;
    end else if (inv_i && (inv_addr_i == tag_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= RstValid;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM ports onto one variable-latency memory; MEM has priority.
// Define MEM_ARBITER_IFETCH_BUF_EN to add a one-entry fetch buffer.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_rdy_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_rdy_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);

  arb_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_rdy_q, if_rdy_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_rdy_q, d_rdy_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  gnt_src_e      gnt_src;
  logic          if_pend, d_pend;
  logic          buf_hit, buf_fill, buf_inv;
  logic [DW-1:0] buf_rdata;

  assign if_pend = if_req_i && !if_rdy_q;
  assign d_pend  = d_req_i && !d_rdy_q;
  assign stall_o = if_pend || d_pend;

`ifdef MEM_ARBITER_IFETCH_BUF_EN
  ifetch_buf #(
    .AW(AW),
    .DW(DW)
  ) u_ifetch_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lookup_addr_i(if_addr_i),
    .hit_o        (buf_hit),
    .rdata_o      (buf_rdata),
    .fill_i       (buf_fill),
    .fill_addr_i  (mem_addr_q),
    .fill_data_i  (mem_rdata_i),
    .inv_i        (buf_inv),
    .inv_addr_i   (mem_addr_q)
  );
`else
  logic unused_buf;
  assign buf_hit    = 1'b0;
  assign buf_rdata  = '0;
  assign unused_buf = buf_fill ^ buf_inv;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdy_d    = if_rdy_q;
    if_rdata_d  = if_rdata_q;
    d_rdy_d     = d_rdy_q;
    d_rdata_d   = d_rdata_q;
    gnt_src     = GntNone;
    buf_fill    = 1'b0;
    buf_inv     = 1'b0;

    // A non-stalled cycle is a pipeline advance: served ports drop rdy.
    if (!stall_o) begin
      if_rdy_d = 1'b0;
      d_rdy_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (d_pend) begin
          gnt_src = GntD;
        end else if (if_pend) begin
          gnt_src = GntI;
        end

        if (gnt_src == GntD) begin
          state_d     = StBusyD;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
        end else if (gnt_src == GntI) begin
          if (buf_hit) begin
            if_rdy_d   = 1'b1;
            if_rdata_d = buf_rdata;
          end else begin
            state_d    = StBusyI;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr_i;
          end
        end
      end

      StBusyI: begin
        if (mem_ack_i) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          buf_fill  = 1'b1;
          // A flushed fetch still completes but is not reported.
          if (if_req_i) begin
            if_rdy_d   = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end
      end

      StBusyD: begin
        if (mem_ack_i) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          buf_inv   = mem_we_q;
          if (d_req_i) begin
            d_rdy_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata_i;
            end
          end
        end
      end

      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RstState;
      mem_req_q   <= RstReq;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdy_q    <= RstRdy;
      if_rdata_q  <= '0;
      d_rdy_q     <= RstRdy;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdy_q    <= if_rdy_d;
      if_rdata_q  <= if_rdata_d;
      d_rdy_q     <= d_rdy_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdy_o    = if_rdy_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdy_o     = d_rdy_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory responder.
module tb_mem_arbiter;

  localparam int Lat = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i, d_req_i, d_we_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i;
  logic        if_rdy_o, d_rdy_o, stall_o;
  logic [31:0] if_rdata_o, d_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  bit          model_ack, force_ack, mem_hold, loaded, req_prev;
  bit   [31:0] model_rdata;
  bit   [31:0] mem_arr [256];
  bit   [31:0] txn_addr[16];
  int          cnt, txn_cnt, t0;
  int          n_total, n_bad;
  bit          done;

  assign mem_ack_i   = model_ack | force_ack;
  assign mem_rdata_i = model_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(32),
    .DW(32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdy_o   (if_rdy_o),
    .if_rdata_o (if_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_rdy_o    (d_rdy_o),
    .d_rdata_o  (d_rdata_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  // Memory responder: ack Lat negedges after mem_req_o is seen.
  always @(negedge clk) begin
    if (!loaded) begin
      mem_arr[8'h40] = 32'h8C010004;
      mem_arr[8'h41] = 32'h11112222;
      mem_arr[8'h80] = 32'h33334444;
      mem_arr[8'h04] = 32'h55556666;
      loaded = 1'b1;
    end
    if (model_ack) begin
      model_ack = 1'b0;
      cnt       = 0;
    end else if (mem_req_o && !mem_hold) begin
      cnt++;
      if (cnt == Lat) begin
        model_ack = 1'b1;
        if (mem_we_o) mem_arr[mem_addr_o[9:2]] = mem_wdata_o;
        else model_rdata = mem_arr[mem_addr_o[9:2]];
      end
    end else begin
      cnt = 0;
    end
    if (mem_req_o && !req_prev) begin
      if (txn_cnt < 16) txn_addr[txn_cnt] = mem_addr_o;
      txn_cnt++;
    end
    req_prev = mem_req_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;
    repeat (3) step();
    check_eq("rst_mem_req", 32'(mem_req_o), 0);
    check_eq("rst_mem_we", 32'(mem_we_o), 0);
    check_eq("rst_mem_addr", mem_addr_o, 0);
    check_eq("rst_mem_wdata", mem_wdata_o, 0);
    check_eq("rst_if_rdy", 32'(if_rdy_o), 0);
    check_eq("rst_d_rdy", 32'(d_rdy_o), 0);
    check_eq("rst_if_rdata", if_rdata_o, 0);
    check_eq("rst_d_rdata", d_rdata_o, 0);
    @(negedge clk) rst_i = 1'b1;
    step();

    // Reset while BUSY_D, then a late ack in IDLE
    mem_hold = 1'b1; d_req_i = 1'b1; d_addr_i = 32'h40;
    step();
    check_eq("busyd_req", 32'(mem_req_o), 1);
    check_eq("busyd_addr", mem_addr_o, 32'h40);
    #2 rst_i = 1'b0;
    #1;
    check_eq("async_rst_req", 32'(mem_req_o), 0);
    check_eq("async_rst_addr", mem_addr_o, 0);
    d_req_i = 1'b0;
    @(negedge clk) rst_i = 1'b1;
    step();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    step();
    check_eq("late_ack_req", 32'(mem_req_o), 0);
    check_eq("late_ack_d_rdy", 32'(d_rdy_o), 0);
    check_eq("late_ack_if_rdy", 32'(if_rdy_o), 0);
    mem_hold = 1'b0;

    // IF only
    t0 = txn_cnt;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    #1 check_eq("if_stall0", 32'(stall_o), 1);
    step();
    check_eq("if_mem_req", 32'(mem_req_o), 1);
    check_eq("if_mem_addr", mem_addr_o, 32'h100);
    check_eq("if_mem_we", 32'(mem_we_o), 0);
    step();
    check_eq("if_wait_rdy", 32'(if_rdy_o), 0);
    check_eq("if_wait_stall", 32'(stall_o), 1);
    step();
    check_eq("if_rdy", 32'(if_rdy_o), 1);
    check_eq("if_rdata", if_rdata_o, 32'h8C010004);
    check_eq("if_stall_done", 32'(stall_o), 0);
    check_eq("if_req_drop", 32'(mem_req_o), 0);
    if_req_i = 1'b0;
    step();
    check_eq("if_rdy_clr", 32'(if_rdy_o), 0);
    check_eq("if_rdata_hold", if_rdata_o, 32'h8C010004);
    check_eq("if_txn", 32'(txn_cnt - t0), 1);

    // Both at once: D first, then IF
    t0 = txn_cnt; done = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h104;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (!stall_o) done = 1'b1;
    end
    check_eq("both_done", 32'(done), 1);
    check_eq("both_if_rdy", 32'(if_rdy_o), 1);
    check_eq("both_d_rdy", 32'(d_rdy_o), 1);
    check_eq("both_if_rdata", if_rdata_o, 32'h11112222);
    check_eq("both_d_rdata", d_rdata_o, 32'h33334444);
    check_eq("both_txn", 32'(txn_cnt - t0), 2);
    check_eq("both_first", txn_addr[t0 % 16], 32'h200);
    check_eq("both_second", txn_addr[(t0 + 1) % 16], 32'h104);
    if_req_i = 1'b0; d_req_i = 1'b0;
    step();
    check_eq("both_clr", 32'({if_rdy_o, d_rdy_o}), 0);

    // D write
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h20; d_wdata_i = 32'hDEADBEEF;
    step();
    check_eq("wr_we", 32'(mem_we_o), 1);
    check_eq("wr_addr", mem_addr_o, 32'h20);
    check_eq("wr_wdata", mem_wdata_o, 32'hDEADBEEF);
    repeat (2) step();
    check_eq("wr_rdy", 32'(d_rdy_o), 1);
    check_eq("wr_rdata_keep", d_rdata_o, 32'h33334444);
    d_req_i = 1'b0; d_we_i = 1'b0;
    step();
    check_eq("wr_rdy_clr", 32'(d_rdy_o), 0);

    // Flush of an in-flight fetch
    t0 = txn_cnt;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    step();
    check_eq("fl_req", 32'(mem_req_o), 1);
    if_req_i = 1'b0;
    repeat (2) step();
    check_eq("fl_rdy", 32'(if_rdy_o), 0);
    check_eq("fl_req_drop", 32'(mem_req_o), 0);
    check_eq("fl_rdata", if_rdata_o, 32'h11112222);
    repeat (2) step();
    check_eq("fl_idle", 32'(mem_req_o), 0);
    check_eq("fl_txn", 32'(txn_cnt - t0), 1);

    // Repeat fetch of 0x10, then write 0x10 and refetch
    if_req_i = 1'b1; if_addr_i = 32'h10;
    repeat (3) step();
    check_eq("rf1_rdy", 32'(if_rdy_o), 1);
    check_eq("rf1_rdata", if_rdata_o, 32'h55556666);
    if_req_i = 1'b0;
    step();
    t0 = txn_cnt;
    if_req_i = 1'b1;
    step();
`ifdef MEM_ARBITER_IFETCH_BUF_EN
    check_eq("rf2_hit_rdy", 32'(if_rdy_o), 1);
    check_eq("rf2_hit_noreq", 32'(mem_req_o), 0);
    check_eq("rf2_hit_rdata", if_rdata_o, 32'h55556666);
`else
    check_eq("rf2_mem_req", 32'(mem_req_o), 1);
    repeat (2) step();
    check_eq("rf2_rdy", 32'(if_rdy_o), 1);
    check_eq("rf2_rdata", if_rdata_o, 32'h55556666);
`endif
    if_req_i = 1'b0;
    step();
`ifdef MEM_ARBITER_IFETCH_BUF_EN
    check_eq("rf2_txn", 32'(txn_cnt - t0), 0);
`else
    check_eq("rf2_txn", 32'(txn_cnt - t0), 1);
`endif
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h10; d_wdata_i = 32'h77778888;
    repeat (3) step();
    check_eq("inv_wr_rdy", 32'(d_rdy_o), 1);
    d_req_i = 1'b0; d_we_i = 1'b0;
    step();
    if_req_i = 1'b1;
    step();
    check_eq("rf3_mem_req", 32'(mem_req_o), 1);
    check_eq("rf3_mem_addr", mem_addr_o, 32'h10);
    repeat (2) step();
    check_eq("rf3_rdy", 32'(if_rdy_o), 1);
    check_eq("rf3_rdata", if_rdata_o, 32'h77778888);
    if_req_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch (IF) port and data-access (MEM) port.
- Sequences each access through a small FSM and holds completed results.
- Drives one global stall so the pipeline advances only once every active request has been served.
- Sits between the IF and MEM stages and the memory model, in place of separate instruction and data memories.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  IF read request (level); held until the pipeline advances.
- if_addr_i  in  AW  fetch address; stable while if_req_i is high.
- if_rdy_o  out  1  IF result valid (level).
- if_rdata_o  out  DW  fetched instruction.
- d_req_i  in  1  MEM-stage request (level).
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  AW  data address.
- d_wdata_i  in  DW  write data.
- d_rdy_o  out  1  data access complete (level).
- d_rdata_o  out  DW  load data.
- stall_o  out  1  pipeline stall, combinational.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  memory write enable, registered.
- mem_addr_o  out  AW  memory address, registered.
- mem_wdata_o  out  DW  memory write data, registered.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
- mem_rdata_i  in  DW  read data, valid when mem_ack_i is high.

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE.
  - All outputs are 0: mem_*, if_rdy_o, d_rdy_o, if_rdata_o, d_rdata_o.
  - Any in-flight memory transaction is abandoned.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If d_req_i & ~d_rdy_o: latch d_addr/we/wdata onto mem_* and go to BUSY_D.
  - Else if if_req_i & ~if_rdy_o: latch if_addr_i, mem_we_o=0, go to BUSY_I.
  - MEM has fixed priority: it is the older instruction.
  - mem_req_o rises the cycle after the grant decision.
- BUSY_x: mem_req_o and the address/data are held stable until mem_ack_i.
- On mem_ack_i in BUSY_x:
  - Next edge: mem_req_o=0, state=IDLE, x_rdy_o=1.
  - For reads, x_rdata_o captures mem_rdata_i.
  - For writes, d_rdata_o is unchanged.
- Minimum latency from request to rdy is 3 cycles (request seen, mem_req_o, ack).
- stall_o = (if_req_i & ~if_rdy_o) | (d_req_i & ~d_rdy_o).
- Any cycle with stall_o=0 counts as a pipeline advance: both rdy flags clear on the next edge. rdata outputs hold their value until overwritten.
- A served port never re-accesses memory while its rdy flag is set, even if its request stays high.
- mem_ack_i in IDLE (late ack after reset or a spurious pulse): ignored, no state change.
- A request deasserted mid-access: the access still completes, and rdy is set only if the request is still high at ack. This lets a flush squash a fetch without a memory protocol violation.
- Simultaneous ack and new request: the new request is evaluated only in IDLE, i.e. one cycle later.

Optional Feature:
- Macro: MEM_ARBITER_IFETCH_BUF_EN.
- With the macro, a one-entry fetch buffer (valid, tag, data) is filled on every completed IF read.
- In IDLE, an IF request whose address equals the tag with valid=1 sets if_rdy_o and if_rdata_o on the next edge with no memory access. The MEM port still has priority on the same cycle.
- A completed data write to the tag address clears valid.
- Reset clears valid.
- Without the macro, every fetch goes to memory.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_I, BUSY_D);
  - the grant-source enum (GNT_NONE, GNT_I, GNT_D);
  - the reset-value constants.
- Sub-module ifetch_buf: tag compare, fill and invalidate. Instantiated only under MEM_ARBITER_IFETCH_BUF_EN.

Test Plan:
- Reset during BUSY_D: d_req_i=1, addr 0x40; rst_i low at the cycle mem_req_o=1 -> mem_req_o=0 immediately; a later ack is ignored; state=IDLE; rdy outputs 0.
- IF only: if_req_i addr 0x100, ack 2 cycles after mem_req_o with rdata 0x8C010004 -> if_rdy_o=1 and if_rdata_o=0x8C010004; stall_o high until that cycle, then 0; if_rdy_o clears next cycle.
- Both request together: IF 0x104 and D read 0x200 -> D served first (mem_addr_o=0x200), then IF (0x104); stall_o stays 1 until both rdy; exactly two mem_req_o transactions.
- D write: addr 0x20, wdata 0xDEADBEEF -> mem_we_o=1 with matching addr/data; d_rdata_o unchanged; d_rdy_o=1 after ack.
- Flush: if_req_i drops while in BUSY_I -> the access completes, if_rdy_o stays 0, state returns to IDLE.
- With the macro: fetch 0x10 twice, the second with no intervening advance to another address -> second if_rdy_o in 1 cycle with no mem_req_o. D write to 0x10, then fetch 0x10 -> memory is accessed.
